spi_flash_arbiter: RTL

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter_pkg.sv | 14 +
 rtl/spi_flash_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter_pkg.sv
// Shared definitions for the dual-master quad-SPI flash arbiter.
// Holds the arbiter state encoding and the flash lane width.
package spi_flash_arbiter_pkg;

  localparam int unsigned LaneW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2,
    StGap  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter that hands one quad-SPI flash to one of two requesters at a time.
// Ownership ends only on a transaction boundary; a deselect gap separates owners.
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int unsigned CS_GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req_i,
  input  logic             m1_req_i,
  output logic             m0_gnt_o,
  output logic             m1_gnt_o,
  input  logic             m0_sclk_i,
  input  logic             m1_sclk_i,
  input  logic             m0_cs_n_i,
  input  logic             m1_cs_n_i,
  input  logic [LaneW-1:0] m0_qdo_i,
  input  logic [LaneW-1:0] m1_qdo_i,
  input  logic [LaneW-1:0] m0_oe_i,
  input  logic [LaneW-1:0] m1_oe_i,
  output logic [LaneW-1:0] m0_qdi_o,
  output logic [LaneW-1:0] m1_qdi_o,
  output logic             sclk_o,
  output logic             cs_n_o,
  output logic [LaneW-1:0] qdo_o,
  output logic [LaneW-1:0] oe_o,
  input  logic [LaneW-1:0] qdi_i
);

  localparam logic [3:0] GapLoad = 4'(CS_GAP);

  arb_state_e state_q;
  logic       last_q;
  logic [3:0] cnt_q;
  logic       gnt0_q;
  logic       gnt1_q;

  // Grants are kept as dedicated flops so the pin mux select never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_req_i && (!m1_req_i || last_q)) begin
            state_q <= StOwn0;
            gnt0_q  <= 1'b1;
          end else if (m1_req_i) begin
            state_q <= StOwn1;
            gnt1_q  <= 1'b1;
          end
        end
        StOwn0: begin
          if (!m0_req_i && m0_cs_n_i) begin
            last_q <= 1'b0;
            gnt0_q <= 1'b0;
            if (GapLoad == 4'd0) begin
              state_q <= StIdle;
            end else begin
              state_q <= StGap;
              cnt_q   <= GapLoad;
            end
          end
        end
        StOwn1: begin
          if (!m1_req_i && m1_cs_n_i) begin
            last_q <= 1'b1;
            gnt1_q <= 1'b0;
            if (GapLoad == 4'd0) begin
              state_q <= StIdle;
            end else begin
              state_q <= StGap;
              cnt_q   <= GapLoad;
            end
          end
        end
        StGap: begin
          // Leave on the edge where the count would reach 1.
          if (cnt_q <= 4'd2) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m0_gnt_o = gnt0_q;
  assign m1_gnt_o = gnt1_q;

  always_comb begin
    sclk_o   = 1'b0;
    cs_n_o   = 1'b1;
    qdo_o    = '0;
    oe_o     = '0;
    m0_qdi_o = '0;
    m1_qdi_o = '0;
    if (gnt0_q) begin
      sclk_o   = m0_sclk_i;
      cs_n_o   = m0_cs_n_i;
      qdo_o    = m0_qdo_i;
      oe_o     = m0_oe_i;
      m0_qdi_o = qdi_i;
    end else if (gnt1_q) begin
      sclk_o   = m1_sclk_i;
      cs_n_o   = m1_cs_n_i;
      qdo_o    = m1_qdo_i;
      oe_o     = m1_oe_i;
      m1_qdi_o = qdi_i;
    end
  end

endmodule
